// File: rtl/conv_out_pkg.sv
// Shared types, default geometry and the requantization helper for the
// convolution output serializer.
package conv_out_pkg;

  localparam int DEF_NUM_TREES   = 2;
  localparam int DEF_IMG_WIDTH   = 6;
  localparam int DEF_IMG_HEIGHT  = 6;
  localparam int DEF_KERNEL_SIZE = 4;
  localparam int DEF_SHIFT       = 4;
  localparam int DEF_BUF_DEPTH   = 4;

  localparam int VALID_COLS = DEF_IMG_WIDTH - DEF_KERNEL_SIZE + 1;
  localparam int VALID_ROWS = DEF_IMG_HEIGHT - DEF_KERNEL_SIZE + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Logical right shift then clamp to the unsigned byte range.
  function automatic logic [7:0] requant(input logic [31:0] pix, input logic [4:0] shift);
    logic [31:0] q;
    q = pix >> shift;
    return (q > 32'd255) ? 8'hFF : q[7:0];
  endfunction

endpackage

// File: rtl/window_fifo.sv
// Synchronous window FIFO; a pop frees its slot for a push in the same cycle,
// so push-while-full succeeds whenever a pop accompanies it.
module window_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         dout_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign dout_next = mem_q[rd_ptr_q + 1'b1];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/conv_output_serializer.sv
// Drops wrap-around windows from convolution_2D, requantizes each tree sum to
// a byte and streams the bytes out tree 0 first with an end-of-frame marker.
module conv_output_serializer
  import conv_out_pkg::*;
#(
  parameter int NUM_TREES   = DEF_NUM_TREES,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int BUF_DEPTH   = DEF_BUF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [32*NUM_TREES-1:0] pixel_in,
  input  logic                    in_valid,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    overflow
);

  localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IDX_W = (NUM_TREES  > 1) ? $clog2(NUM_TREES)  : 1;
  localparam int EW    = NUM_TREES * 8 + 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  localparam logic [CW-1:0]    LAST_VCOL = CW'(IMG_WIDTH - KERNEL_SIZE);
  localparam logic [CW-1:0]    LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]    LAST_VROW = RW'(IMG_HEIGHT - KERNEL_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TREES - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             overflow_q, overflow_d;
  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             win_valid, frame_last, push, pop;
  logic [EW-1:0]    wr_data, fifo_head, fifo_next;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       head_bytes [NUM_TREES];
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    win_valid  = (col_q <= LAST_VCOL);
    frame_last = (row_q == LAST_VROW) && (col_q == LAST_VCOL);
    if (in_valid) begin
      if (frame_last) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int t = 0; t < NUM_TREES; t++) begin
      wr_data[8*t +: 8] = requant(pixel_in[32*t +: 32], 5'(SHIFT));
    end
    wr_data[EW-1] = frame_last;
  end

  // A full FIFO still accepts the window when the head pops in the same cycle.
  assign push       = in_valid && win_valid;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  window_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .din       (wr_data),
    .pop       (pop),
    .dout      (fifo_head),
    .dout_next (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    for (int t = 0; t < NUM_TREES; t++) head_bytes[t] = fifo_head[8*t +: 8];
  end

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          out_data_d  = head_bytes[0];
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_inc;
            out_data_d = head_bytes[idx_inc];
          end else begin
            pop = 1'b1;
            // Chain straight into the next buffered window to avoid a bubble.
            if (fifo_count >= CNT_W'(2)) begin
              out_data_d = fifo_next[7:0];
              idx_d      = '0;
            end else begin
              out_valid_d = 1'b0;
              state_d     = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (idx_q == LAST_IDX) && fifo_head[EW-1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_output_serializer.sv
// Randomized and directed bench for conv_output_serializer against a queue-based
// window/byte model.
module tb_conv_output_serializer;

  localparam int NT = 2, W = 6, H = 6, K = 4, SH = 4, D = 4;
  localparam int LASTPOS = (H - K) * W + (W - K);

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pixel_in;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;

  always #5 clock = ~clock;

  conv_output_serializer dut (
    .clock     (clock),
    .reset     (reset),
    .pixel_in  (pixel_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [16:0] mq [$];
  bit          m_send = 0;
  int          m_idx  = 0;
  int          m_pos  = 0;
  bit          m_ovf  = 0;

  logic [7:0] got [$];
  bit         got_last [$];

  function automatic logic [7:0] rq(input logic [31:0] x);
    longint v;
    v = longint'(x) / (2 ** SH);
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of windows plus the byte currently presented.
  always @(posedge clock) begin
    int pre, col;
    bit pop, accept, last;
    logic [16:0] ent;
    if (reset) begin
      mq.delete();
      m_send = 0; m_idx = 0; m_pos = 0; m_ovf = 0;
    end else begin
      pre    = mq.size();
      pop    = m_send && out_ready && (m_idx == NT - 1);
      accept = 0;
      ent    = '0;
      if (in_valid) begin
        col  = m_pos % W;
        last = (m_pos == LASTPOS);
        m_pos = last ? 0 : m_pos + 1;
        if (col <= W - K) begin
          ent = {last, rq(pixel_in[63:32]), rq(pixel_in[31:0])};
          if (pre < D || pop) accept = 1;
          else m_ovf = 1;
        end
      end
      if (!m_send) begin
        if (pre > 0) begin m_send = 1; m_idx = 0; end
      end else if (out_ready) begin
        if (m_idx < NT - 1) m_idx++;
        else begin
          void'(mq.pop_front());
          if (pre >= 2) m_idx = 0;
          else m_send = 0;
        end
      end
      if (accept) mq.push_back(ent);
    end
  end

  always @(negedge clock) begin
    logic [16:0] h;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_send});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_send && mq.size() > 0) begin
      h = mq[0];
      chk("out_data", {24'd0, out_data}, {24'd0, h[m_idx*8 +: 8]});
      chk("out_last", {31'd0, out_last}, {31'd0, (m_idx == NT - 1) && h[16]});
    end else begin
      chk("out_last_idle", {31'd0, out_last}, 32'd0);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic cyc(input bit iv, input logic [31:0] t0, input logic [31:0] t1);
    in_valid = iv;
    pixel_in = {t1, t0};
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    got.delete();
    got_last.delete();
  endtask

  task automatic chk_stream(input string name, input logic [7:0] exp [$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] exp [$];
    logic [31:0] a, b;
    int nlast, lastpos;
    logic [7:0] d0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pixel_in = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Basic ordering and latency
    do_reset();
    cyc(1, 32'd252, 32'd412);
    chk("basic_lat_n", {31'd0, out_valid}, 32'd0);
    cyc(1, 32'd276, 32'd452);
    chk("basic_lat_n1", {31'd0, out_valid}, 32'd1);
    chk("basic_first", {24'd0, out_data}, 32'd15);
    idle(6);
    exp = '{8'd15, 8'd25, 8'd17, 8'd28};
    chk_stream("basic", exp);

    // Column gating
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1, 32'(16 * k), 32'd0);
    idle(6);
    exp = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd2, 8'd0};
    chk_stream("colgate", exp);

    // Frame end plus first window of the next frame
    do_reset();
    exp.delete();
    lastpos = -1;
    for (int i = 0; i < LASTPOS + 2; i++) begin
      a = $urandom_range(0, 8191);
      b = $urandom_range(0, 4095);
      if (i <= LASTPOS ? ((i % W) <= W - K) : 1) begin
        exp.push_back(rq(a));
        exp.push_back(rq(b));
        if (i == LASTPOS) lastpos = exp.size() - 1;
      end
      cyc(1, a, b);
    end
    idle(10);
    chk_stream("frame", exp);
    chk("frame_bytes", exp.size(), 32'd20);
    nlast = 0;
    foreach (got_last[i]) if (got_last[i]) nlast++;
    chk("frame_nlast", nlast, 32'd1);
    if (got_last.size() > 17) chk("frame_last_pos", {31'd0, got_last[17]}, 32'd1);
    else chk("frame_last_pos", got_last.size(), 32'd18);
    chk("frame_lastidx", lastpos, 32'd17);

    // Saturation
    do_reset();
    cyc(1, 32'h0000_1000, 32'hFFFF_FFFF);
    idle(4);
    exp = '{8'd255, 8'd255};
    chk_stream("sat", exp);

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1, 32'(16 * (k + 1)), 32'(16 * (k + 50)));
    idle(2);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    d0 = out_data;
    chk("bp_head", {24'd0, d0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("bp_stable", {24'd0, out_data}, {24'd0, d0});
    end
    out_ready = 1'b1;
    idle(12);
    exp = '{8'd1, 8'd50, 8'd2, 8'd51, 8'd3, 8'd52, 8'd7, 8'd56};
    chk_stream("bp", exp);

    // Reset mid-frame with two windows buffered
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1, 32'd160, 32'd176);
    idle(1);
    chk("mid_sending", {31'd0, out_valid}, 32'd1);
    do_reset();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    exp.delete();
    for (int i = 0; i <= LASTPOS; i++) begin
      if ((i % W) <= W - K) begin
        exp.push_back(8'(i + 1));
        exp.push_back(8'(i));
      end
      cyc(1, 32'(16 * (i + 1)), 32'(16 * i));
    end
    idle(10);
    chk_stream("mid_frame", exp);
    if (got_last.size() == 18) chk("mid_last", {31'd0, got_last[17]}, 32'd1);
    else chk("mid_last_len", got_last.size(), 32'd18);

    // Randomized traffic checked cycle by cycle against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 4095);
      b = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 4095);
      cyc($urandom_range(0, 3) != 0, a, b);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
